// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared types and helpers for the MIPS-lite writeback stage.
// Revision: 1.0
`default_nettype none

package wb_stage_pkg;

   localparam int NREGS_DEF = 32;
   localparam int DATA_W    = 32;

   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
   } instruct_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } ctrl_t;

   typedef enum logic [5:0] {
      OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
      OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
      OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
      OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
      OP_JR   = 6'h10, OP_HALT = 6'h11
   } opcode_e;

   typedef enum logic [2:0] {
      CLS_ARITH, CLS_LOGIC, CLS_MEM, CLS_CTRL, CLS_NONE
   } iclass_e;

   typedef enum logic [0:0] {
      ST_RUN, ST_HALTED
   } state_e;

   function automatic iclass_e op_class(input logic [5:0] op);
      if (op <= OP_MULI)      return CLS_ARITH;
      else if (op <= OP_XORI) return CLS_LOGIC;
      else if (op <= OP_STW)  return CLS_MEM;
      else if (op <= OP_HALT) return CLS_CTRL;
      else                    return CLS_NONE;
   endfunction

   // Register-register forms are the even opcodes of the ALU group.
   function automatic logic is_rtype(input logic [5:0] op);
      return (op <= OP_XOR) && !op[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile.sv
// wb_regfile: register file with one write port and two write-bypassed read ports.
// Revision: 1.0
`default_nettype none

module wb_regfile
   import wb_stage_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  data_t         wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output data_t         rdata_a,
   output data_t         rdata_b
);

   data_t regs [NREGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0)                 ? '0    :
                    (we && (waddr == raddr_a))      ? wdata : regs[raddr_a];
   assign rdata_b = (raddr_b == '0)                 ? '0    :
                    (we && (waddr == raddr_b))      ? wdata : regs[raddr_b];

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, register file, retirement counters and HALT handling.
// Revision: 1.0
`default_nettype none

module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int CNT_W = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  instruct_t        instrMem,
   input  data_t            memory_data_o,
   input  data_t            write_back_data,
   input  ctrl_t            cntrl,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output data_t            rd_data_a,
   output data_t            rd_data_b,
   output logic             wb_en,
   output logic [AW-1:0]    wb_addr,
   output data_t            wb_value,
   output logic             halted,
   output logic [CNT_W-1:0] cnt_total,
   output logic [CNT_W-1:0] cnt_arith,
   output logic [CNT_W-1:0] cnt_logic,
   output logic [CNT_W-1:0] cnt_mem,
   output logic [CNT_W-1:0] cnt_ctrl
);

   logic       v_q;
   logic [5:0] op_q;
   logic [4:0] rt_q;
   logic [4:0] rd_q;
   data_t      mem_q;
   data_t      alu_q;
   ctrl_t      ctl_q;
   state_e     state;
   logic       retire;
   logic       unused_fields;

   // Source register and immediate were consumed upstream.
   assign unused_fields = ^{instrMem.rs, instrMem.imm};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= 1'b0;
         op_q  <= '0;
         rt_q  <= '0;
         rd_q  <= '0;
         mem_q <= '0;
         alu_q <= '0;
         ctl_q <= '0;
      end else if (flush) begin
         v_q <= 1'b0;
      end else if (!stall) begin
         v_q   <= in_valid;
         op_q  <= instrMem.opcode;
         rt_q  <= instrMem.rt;
         rd_q  <= instrMem.rd;
         mem_q <= memory_data_o;
         alu_q <= write_back_data;
         ctl_q <= cntrl;
      end
   end

   assign wb_value = ctl_q.mem_to_reg ? mem_q : alu_q;
   assign wb_addr  = is_rtype(op_q) ? AW'(rd_q) : AW'(rt_q);
   assign retire   = v_q && !stall && (state == ST_RUN);
   assign wb_en    = retire && ctl_q.reg_write && (wb_addr != '0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         halted    <= 1'b0;
         cnt_total <= '0;
         cnt_arith <= '0;
         cnt_logic <= '0;
         cnt_mem   <= '0;
         cnt_ctrl  <= '0;
      end else if (retire) begin
         cnt_total <= sat_inc(cnt_total);
         case (op_class(op_q))
            CLS_ARITH: cnt_arith <= sat_inc(cnt_arith);
            CLS_LOGIC: cnt_logic <= sat_inc(cnt_logic);
            CLS_MEM:   cnt_mem   <= sat_inc(cnt_mem);
            CLS_CTRL:  cnt_ctrl  <= sat_inc(cnt_ctrl);
            default:   ;
         endcase
         if (op_q == OP_HALT) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
         end
      end
   end

   wb_regfile #(
      .NREGS (NREGS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_value),
      .raddr_a (rd_addr_a),
      .raddr_b (rd_addr_b),
      .rdata_a (rd_data_a),
      .rdata_b (rd_data_b)
   );

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) stage of the 5-stage MIPS-lite pipeline; directly downstream of the memory-access stage and consumes its instruction, load data, pass-through ALU result and control bundle.
- Holds the MEM/WB pipeline register, the 32-entry register file (one write port, two read ports with same-cycle bypass) and the retirement statistics counters.
- Owns HALT retirement and asserts `halted` so the testbench can stop the trace.

Parameters:
- NREGS, 32, register-file depth (index width = $clog2(NREGS)).
- CNT_W, 32, width of every statistics counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents a valid instruction this cycle.
- stall  in  1  hold the MEM/WB register (hazard unit).
- flush  in  1  load a bubble into MEM/WB.
- instrMem  in  Instruct  instruction from the memory stage (opcode[5:0], rs, rt, rd, imm).
- memory_data_o  in  DATA  load data from the memory stage.
- write_back_data  in  DATA  ALU result from the memory stage.
- cntrl  in  CTRL  control bundle (regWrite, memToReg used here).
- rd_addr_a, rd_addr_b  in  5 each  register read addresses (decode stage).
- rd_data_a, rd_data_b  out  DATA each  register read data.
- wb_en  out  1  register write is happening this cycle (forwarding unit).
- wb_addr  out  5  destination register of that write.
- wb_value  out  DATA  value being written.
- halted  out  1  HALT has retired.
- cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl  out  CNT_W each  retired-instruction counters.

Behaviour:
- Reset (rst low, asynchronous):
  - MEM/WB valid=0; all registers=0; all counters=0.
  - State=RUN; halted=0; wb_en=0.
- MEM/WB register, on each clock edge:
  - flush wins over stall and clears valid.
  - Else, stall holds the register.
  - Else, captures in_valid, instrMem, memory_data_o, write_back_data, cntrl.
- Writeback, combinational from the MEM/WB register (retirement is visible one cycle after capture):
  - wb_value = memToReg ? load data : ALU result.
  - wb_addr = rd for R-type opcodes (ADD 0x00, SUB 0x02, MUL 0x04, OR 0x06, AND 0x08, XOR 0x0A); otherwise rt.
  - wb_en = valid & regWrite & (state==RUN) & (wb_addr!=0) & !stall.
- Register write occurs at the edge while wb_en=1. R0 always reads 0; writes to R0 are dropped.
- Read ports:
  - Combinational.
  - If wb_en and wb_addr==rd_addr_x and rd_addr_x!=0, return wb_value (write-before-read bypass).
  - Otherwise return the stored value.
- A retirement occurs at an edge where valid=1, !stall and state==RUN. On each retirement:
  - cnt_total increments.
  - Exactly one class counter increments:
    - arith: opcodes 0x00–0x05.
    - logic: 0x06–0x0B.
    - mem: LDW 0x0C, STW 0x0D.
    - ctrl: BZ 0x0E, BEQ 0x0F, JR 0x10, HALT 0x11.
  - Undefined opcodes count in total only.
- Counters saturate at all-ones; no wrap.
- FSM:
  - RUN -> HALTED when HALT (0x11) retires. HALT counts in total and ctrl.
  - HALTED is terminal until reset: no register writes, no counter changes, halted=1 from the cycle after the HALT edge.
- Boundary conditions:
  - HALT arriving with stall=1 does not retire until stall drops.
  - flush and stall together: flush wins.
  - STW/BZ/BEQ/JR carry regWrite=0, so they produce no write but still count.
  - Reset asserted mid-operation clears everything immediately, independent of clk.

Decomposition:
- Shared package (TYPES): Instruct, CTRL, DATA, opcode enum (ADD..HALT), instruction-class enum, NREGS default.
- One sub-module: wb_regfile (NREGS x DATA array, async reset, write port, two bypassed read ports, R0 forced zero).
- Counters, FSM and the MEM/WB register stay in wb_stage.

Test Plan:
1. Reset then ADDI R1 (rt=1) with write_back_data=0x5, regWrite=1 -> next cycle wb_en=1, wb_addr=1; afterwards rd_data_a(1)=0x5; cnt_arith=1, cnt_total=1.
2. LDW R2 with memToReg=1, memory_data_o=0xDEADBEEF, write_back_data=0x40 -> R2=0xDEADBEEF; cnt_mem=1. Reading R2 in the same cycle as the write returns 0xDEADBEEF (bypass).
3. ADD targeting rd=0 with value 0x7 -> wb_en=0; rd_data(0)=0; cnt_arith still increments.
4. Hold stall=1 for 3 cycles with a valid XOR -> no counter change and no write during the stall; exactly one retirement after release. Same sequence with flush=1 -> zero retirements.
5. HALT followed by ADDI R3=0x9 -> halted=1; cnt_ctrl=1; R3 stays 0; cnt_total frozen. Pulse rst low mid-cycle -> all outputs 0, halted=0.
6. Preload cnt_total to all-ones via backdoor force, then retire one more -> stays 0xFFFFFFFF.
